// File: rtl/register_file_8x16_if.sv
// Bus interface for register_file_8x16: one write port, two read ports and
// the committed-write debug counter.
interface register_file_8x16_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();
    logic              RegWrite;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [7:0]        WrCount;

    modport master (
        output RegWrite, WA, WD, RA1, RA2,
        input  RD1, RD2, WrCount
    );

    modport slave (
        input  RegWrite, WA, WD, RA1, RA2,
        output RD1, RD2, WrCount
    );
endinterface

// File: rtl/register_file_8x16.sv
// 2**ADDR_W x DATA_W register file, R0 hard-wired to zero, two combinational read ports.
// Optional write-through bypass: define REGFILE_WRITE_BYPASS_EN.
module register_file_8x16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    register_file_8x16_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [7:0]        wr_count_r;
    logic              wr_en_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // A write commits only when enabled and aimed at a non-zero register.
    always_comb begin
        wr_en_s = 1'b0;
        if (bus.RegWrite == 1'b1 && bus.WA != {ADDR_W{1'b0}}) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register array and write counter; R0 is only ever loaded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            wr_count_r <= 8'd0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en_s && bus.WA == ADDR_W'(i)) begin
                    regs_r[i] <= bus.WD;
                end
            end
            if (wr_en_s) begin
                wr_count_r <= wr_count_r + 8'd1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] val;
        val = {DATA_W{1'b0}};
        if (rst || ra == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else begin
`ifdef REGFILE_WRITE_BYPASS_EN
            // Forward the in-flight write so the reader sees it this cycle.
            if (wr_en_s && ra == bus.WA) begin
                val = bus.WD;
            end else begin
                val = regs_r[ra];
            end
`else
            val = regs_r[ra];
`endif
        end
        return val;
    endfunction

    // Independent combinational read ports.
    always_comb begin
        rd1_s = {DATA_W{1'b0}};
        rd2_s = {DATA_W{1'b0}};
        rd1_s = read_port(bus.RA1);
        rd2_s = read_port(bus.RA2);
    end

    assign bus.RD1     = rd1_s;
    assign bus.RD2     = rd2_s;
    assign bus.WrCount = wr_count_r;
endmodule

// File: tb/tb_register_file_8x16.sv
// Directed self-checking bench for register_file_8x16 (default or bypass build).
module tb_register_file_8x16;
    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;

    register_file_8x16_if #(.DATA_W(16), .ADDR_W(3)) rf_if ();

    register_file_8x16 #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One committed write: present at negedge, captured by the following posedge.
    task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        rf_if.RegWrite = 1'b1;
        rf_if.WA       = addr;
        rf_if.WD       = data;
        @(negedge clk);
        rf_if.RegWrite = 1'b0;
    endtask

    task automatic read_both(input logic [2:0] a1, input logic [2:0] a2);
        rf_if.RA1 = a1;
        rf_if.RA2 = a2;
        #1;
    endtask

    logic [15:0] exp_bypass;

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        rf_if.RegWrite = 1'b0;
        rf_if.WA  = 3'd0;
        rf_if.WD  = 16'h0000;
        rf_if.RA1 = 3'd0;
        rf_if.RA2 = 3'd0;
        repeat (2) @(negedge clk);

        read_both(3'd3, 3'd7);
        check_eq("reset_rd1", 32'(rf_if.RD1), 32'h0000);
        check_eq("reset_rd2", 32'(rf_if.RD2), 32'h0000);
        check_eq("reset_cnt", 32'(rf_if.WrCount), 32'd0);
        rst = 1'b0;

        do_write(3'd2, 16'h0042);
        do_write(3'd3, 16'h1234);
        read_both(3'd3, 3'd2);
        check_eq("load_r3", 32'(rf_if.RD1), 32'h1234);
        check_eq("load_r2", 32'(rf_if.RD2), 32'h0042);
        check_eq("load_cnt", 32'(rf_if.WrCount), 32'd2);

        // Mid-cycle reset with a pending write to R6
        @(negedge clk);
        rf_if.RegWrite = 1'b1;
        rf_if.WA = 3'd6;
        rf_if.WD = 16'hDEAD;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_rd1", 32'(rf_if.RD1), 32'h0000);
        check_eq("async_rst_cnt", 32'(rf_if.WrCount), 32'd0);
        @(negedge clk);
        read_both(3'd6, 3'd3);
        check_eq("rst_hold_r6", 32'(rf_if.RD1), 32'h0000);
        check_eq("rst_hold_cnt", 32'(rf_if.WrCount), 32'd0);
        rf_if.RegWrite = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("lost_write_r6", 32'(rf_if.RD1), 32'h0000);
        check_eq("post_rst_r3", 32'(rf_if.RD2), 32'h0000);

        do_write(3'd5, 16'hA5A5);
        read_both(3'd5, 3'd5);
        check_eq("r5_port1", 32'(rf_if.RD1), 32'hA5A5);
        check_eq("r5_port2", 32'(rf_if.RD2), 32'hA5A5);
        check_eq("r5_cnt", 32'(rf_if.WrCount), 32'd1);

        do_write(3'd2, 16'h0042);
        @(negedge clk);
        rf_if.RegWrite = 1'b0;
        rf_if.WA = 3'd2;
        rf_if.WD = 16'h7777;
        repeat (3) @(negedge clk);
        rf_if.WA = 3'bxxx;
        rf_if.WD = 16'hxxxx;
        read_both(3'bxxx, 3'bxxx);
        repeat (2) @(negedge clk);
        read_both(3'd2, 3'd5);
        check_eq("no_we_r2", 32'(rf_if.RD1), 32'h0042);
        check_eq("x_addr_r5", 32'(rf_if.RD2), 32'hA5A5);
        check_eq("no_we_cnt", 32'(rf_if.WrCount), 32'd2);

        // Write to R0 is discarded, including in the same cycle
        @(negedge clk);
        rf_if.RegWrite = 1'b1;
        rf_if.WA = 3'd0;
        rf_if.WD = 16'hFFFF;
        read_both(3'd0, 3'd0);
        check_eq("r0_same_cycle", 32'(rf_if.RD1), 32'h0000);
        @(negedge clk);
        rf_if.RegWrite = 1'b0;
        #1;
        check_eq("r0_after", 32'(rf_if.RD1), 32'h0000);
        check_eq("r0_cnt", 32'(rf_if.WrCount), 32'd2);

        // Same-cycle write/read of R4
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_bypass = 16'hBEEF;
`else
        exp_bypass = 16'h0000;
`endif
        @(negedge clk);
        rf_if.RegWrite = 1'b1;
        rf_if.WA = 3'd4;
        rf_if.WD = 16'hBEEF;
        read_both(3'd4, 3'd5);
        check_eq("r4_before_edge", 32'(rf_if.RD1), 32'(exp_bypass));
        check_eq("r5_indep", 32'(rf_if.RD2), 32'hA5A5);
        @(negedge clk);
        rf_if.RegWrite = 1'b0;
        #1;
        check_eq("r4_after_edge", 32'(rf_if.RD1), 32'hBEEF);
        check_eq("r4_cnt", 32'(rf_if.WrCount), 32'd3);

        // Counter wrap: clear, then 256 writes to R1
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            do_write(3'd1, 16'h1000 + 16'(i));
            if (i == 254) begin
                check_eq("cnt_255", 32'(rf_if.WrCount), 32'd255);
            end
        end
        read_both(3'd1, 3'd4);
        check_eq("wrap_cnt", 32'(rf_if.WrCount), 32'd0);
        check_eq("wrap_r1", 32'(rf_if.RD1), 32'h10FF);
        check_eq("wrap_r4_cleared", 32'(rf_if.RD2), 32'h0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
